// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch, decode and hazard stages:
// reset PC, the bubble instruction and the fetch redirect states.
package pipe_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority is reset, then flush, then stall,
// then load. A bubble keeps the previous PC fields.
module if_id_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] pc_plus4_in,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!stall) begin
            if (load_valid) begin
                instr    <= instr_in;
                pc       <= pc_in;
                pc_plus4 <= pc_plus4_in;
                valid    <= 1'b1;
            end else begin
                instr <= NOP_INSTR;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_adder.sv
// Parameterised PC adder. It is shared by the fetch and execute stages
// and wraps modulo 2^WIDTH.
module pc_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage. It holds the fetch PC, handles redirects while a
// memory access is outstanding, and drives IF/ID. PC_ALIGN_CHECK_EN adds misalign_d.
module fetch_pc_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = pipe_pkg::RESET_PC,
    parameter logic [WIDTH-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             pc_src_e,
    input  logic [WIDTH-1:0] pc_target_e,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] instr_d,
    output logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pc_plus4_d,
    output logic             valid_d
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misalign_d
`endif
);

    import pipe_pkg::*;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    fetch_state_t     state, state_next;
    logic [WIDTH-1:0] pend_tgt;
    logic [WIDTH-1:0] pc_plus4_f;
    logic [WIDTH-1:0] redir_raw;
    logic [WIDTH-1:0] redir_tgt;
    logic [WIDTH-1:0] pc_next;
    logic             fetch_done;
    logic             redir;
    logic             load_valid;

    assign fetch_done = imem_ready & ~stall_f;
    assign redir      = pc_src_e | (state == PEND);
    assign load_valid = fetch_done & ~redir;
    assign imem_addr  = pc_f;

    pc_adder #(.WIDTH(WIDTH)) u_pc_plus4 (
        .a   (pc_f),
        .b   (PC_STEP),
        .sum (pc_plus4_f)
    );

    // A target arriving in the same cycle takes priority over a pending target.
    assign redir_raw = pc_src_e ? pc_target_e : pend_tgt;
`ifdef PC_ALIGN_CHECK_EN
    assign redir_tgt = {redir_raw[WIDTH-1:2], 2'b00};
`else
    assign redir_tgt = redir_raw;
`endif
    assign pc_next = redir ? redir_tgt : pc_plus4_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (fetch_done) begin
            pc_f <= pc_next;
        end
    end

    // The stored target is only used in PEND. Reset returns to RUN, so it needs no reset.
    always_ff @(posedge clk) begin
        if (pc_src_e && !fetch_done) begin
            pend_tgt <= pc_target_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            imem_req <= 1'b0;
        end else begin
            state    <= state_next;
            imem_req <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (pc_src_e && !fetch_done) state_next = PEND;
            PEND:    if (fetch_done) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    if_id_reg #(
        .WIDTH     (WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush_d),
        .stall       (stall_d),
        .load_valid  (load_valid),
        .instr_in    (imem_rdata),
        .pc_in       (pc_f),
        .pc_plus4_in (pc_plus4_f),
        .instr       (instr_d),
        .pc          (pc_d),
        .pc_plus4    (pc_plus4_d),
        .valid       (valid_d)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_f;

    // Set by a misaligned redirect. Cleared once the first instruction from that target is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_f <= 1'b0;
        end else if (fetch_done) begin
            misalign_f <= redir & (|redir_raw[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_d <= 1'b0;
        end else if (flush_d) begin
            misalign_d <= 1'b0;
        end else if (!stall_d) begin
            misalign_d <= load_valid & misalign_f;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage. It uses a reference PC model and a scoreboard of expected Decode outputs.
// Build with PC_ALIGN_CHECK_EN to also cover the misalign_d output.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f, stall_d, flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_d;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_pc_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_d  (misalign_d)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        mis;
    } sb_item_t;

    sb_item_t    sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_tgt   = 32'h0;
    logic        m_pend  = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_mis   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    function automatic logic mis_of(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return |t[1:0];
`else
        return (t == 32'hFFFF_FFFF) & 1'b0;
`endif
    endfunction

    // Advance one clock. The model is updated from the inputs currently driven.
    task automatic tick();
        logic     fd, rd, deliver;
        logic [31:0] t;
        sb_item_t it;
        fd      = imem_ready & ~stall_f;
        rd      = pc_src_e | m_pend;
        deliver = ~reset & ~flush_d & ~stall_d & fd & ~rd;
        if (deliver) sb.push_back('{mem(m_pc), m_pc, m_pc + 32'd4, m_mis});
        if (reset) begin
            m_pc = 32'h0; m_pend = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
        end else begin
            if (flush_d) m_valid = 1'b0;
            else if (!stall_d) m_valid = deliver;
            if (fd) begin
                t = pc_src_e ? pc_target_e : m_tgt;
                if (rd) begin
                    m_pc = align(t); m_mis = mis_of(t);
                end else begin
                    m_pc = m_pc + 32'd4; m_mis = 1'b0;
                end
                m_pend = 1'b0;
            end else if (pc_src_e) begin
                m_tgt = pc_target_e; m_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("pc_f", pc_f, m_pc);
        chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
        if (deliver && sb.size() > 0) begin
            it = sb.pop_front();
            chk("sb_instr_d", instr_d, it.instr);
            chk("sb_pc_d", pc_d, it.pc);
            chk("sb_pc_plus4_d", pc_plus4_d, it.pc4);
`ifdef PC_ALIGN_CHECK_EN
            chk("sb_misalign_d", {31'b0, misalign_d}, {31'b0, it.mis});
`endif
        end
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = 32'h0; imem_ready = 1'b0;

        tick();
        chk("rst_pc_f", pc_f, 32'h0);
        chk("rst_instr_d", instr_d, 32'h13);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_pc_plus4_d", pc_plus4_d, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);

        // sequential fetch with zero-wait memory
        reset = 1'b0; imem_ready = 1'b1;
        tick();
        chk("req_after_reset", {31'b0, imem_req}, 32'h1);
        chk("seq_pc_1", pc_f, 32'h4);
        tick();
        tick();
        chk("seq_pc_3", pc_f, 32'hC);
        chk("seq_pc_d", pc_d, 32'h8);
        tick();

        // redirect while memory is ready
        pc_src_e = 1'b1; pc_target_e = 32'h80;
        tick();
        chk("redir_pc_f", pc_f, 32'h80);
        chk("redir_bubble", instr_d, 32'h13);
        pc_src_e = 1'b0;
        tick();
        chk("redir_first_pc_d", pc_d, 32'h80);

        // redirects while memory waits: newest target wins
        imem_ready = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'h200;
        tick();
        chk("pend_addr_1", imem_addr, 32'h84);
        chk("pend_state", 32'(dut.state), 32'(pipe_pkg::PEND));
        pc_target_e = 32'h300;
        tick();
        chk("pend_addr_2", imem_addr, 32'h84);
        pc_src_e = 1'b0;
        tick();
        chk("pend_addr_3", imem_addr, 32'h84);
        imem_ready = 1'b1;
        tick();
        chk("pend_pc_f", pc_f, 32'h300);
        chk("pend_bubble", instr_d, 32'h13);

        // stall both stages, then flush
        tick();
        stall_f = 1'b1; stall_d = 1'b1;
        tick();
        tick();
        chk("stall_pc_f", pc_f, 32'h304);
        chk("stall_instr_d", instr_d, mem(32'h300));
        chk("stall_pc_d", pc_d, 32'h300);
        chk("stall_pc_plus4_d", pc_plus4_d, 32'h304);
        stall_d = 1'b0; flush_d = 1'b1;
        tick();
        chk("flush_instr_d", instr_d, 32'h13);
        chk("flush_pc_d_hold", pc_d, 32'h300);
        flush_d = 1'b0; stall_f = 1'b0;

        // wrap-around of PC arithmetic
        pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
        tick();
        pc_src_e = 1'b0;
        tick();
        chk("wrap_pc_f", pc_f, 32'h0);
        chk("wrap_pc_plus4_d", pc_plus4_d, 32'h0);
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);

        // reset while a redirect is pending discards it
        imem_ready = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'h400;
        tick();
        pc_src_e = 1'b0; reset = 1'b1;
        tick();
        chk("rst_pend_req", {31'b0, imem_req}, 32'h0);
        reset = 1'b0; imem_ready = 1'b1;
        tick();
        chk("rst_pend_pc_f", pc_f, 32'h4);

`ifdef PC_ALIGN_CHECK_EN
        pc_src_e = 1'b1; pc_target_e = 32'h102;
        tick();
        chk("align_pc_f", pc_f, 32'h100);
        pc_src_e = 1'b0;
        tick();
        chk("align_mis_first", {31'b0, misalign_d}, 32'h1);
        chk("align_pc_d", pc_d, 32'h100);
        tick();
        chk("align_mis_next", {31'b0, misalign_d}, 32'h0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: holds the fetch PC, computes the sequential PC (PC+4) and selects the redirect target from Execute.
- Issues fetch addresses to instruction memory, which may take several cycles (ready handshake).
- Drives the IF/ID pipeline register that feeds Decode.
- Feeds the PC adders and consumes their sum as next-PC.

Parameters:
WIDTH, 32, address/data width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction inserted into Decode

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
stall_f  in  1  hazard unit: hold fetch PC
stall_d  in  1  hazard unit: hold IF/ID register
flush_d  in  1  hazard unit: bubble IF/ID register
pc_src_e  in  1  one-cycle pulse, redirect taken in Execute
pc_target_e  in  WIDTH  redirect target
imem_addr  out  WIDTH  fetch address (= pc_f)
imem_req  out  1  fetch request valid
imem_rdata  in  WIDTH  instruction, valid when imem_ready=1
imem_ready  in  1  memory returns imem_rdata this cycle
pc_f  out  WIDTH  current fetch PC
instr_d  out  WIDTH  Decode instruction
pc_d  out  WIDTH  Decode PC
pc_plus4_d  out  WIDTH  Decode PC+4
valid_d  out  1  instr_d is a real instruction

Behaviour:
- Reset, highest priority, clocked: pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, state=RUN, imem_req=0 in the reset cycle and 1 in every later cycle.
- Advance term: fetch_done = imem_ready & ~stall_f. pc_f updates only on fetch_done.
- Redirect term: redir = pc_src_e | (state==PEND).
- Next PC = pc_src_e ? pc_target_e : (state==PEND ? pend_tgt : pc_f+4).
- PC arithmetic is modulo 2^WIDTH. pc_f=32'hFFFF_FFFC gives pc_plus4 = 0.
- State RUN:
  - pc_src_e & fetch_done: pc_f <= pc_target_e; IF/ID loads a bubble; stay in RUN.
  - pc_src_e & ~fetch_done: pend_tgt <= pc_target_e; go to PEND. The in-flight request is not cancelled; imem_addr stays pc_f.
- State PEND:
  - fetch_done: pc_f <= pend_tgt, or pc_target_e if pc_src_e is high the same cycle (newest target wins); IF/ID loads a bubble; go to RUN.
  - ~fetch_done with pc_src_e: pend_tgt overwritten with the new target.
- IF/ID register priority: reset > flush_d > stall_d > load.
  - flush_d: instr_d=NOP_INSTR, valid_d=0; pc_d and pc_plus4_d hold their values.
  - load with fetch_done & ~redir: instr_d=imem_rdata, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1.
  - load otherwise (memory wait or redirect): bubble (NOP_INSTR, valid_d=0).
- Latency: an instruction returned at edge N appears on instr_d after edge N. Zero-wait memory gives one instruction per cycle.
- stall_f without stall_d: legal. Decode receives bubbles.
- Reset mid-PEND: the pending redirect is discarded.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Extra output misalign_d (1 bit, reset 0).
  - A redirect target with target[1:0]!=0 is loaded into pc_f with bits [1:0] cleared.
  - The first instruction delivered from that target carries misalign_d=1; all others carry 0.
  - A bubble always carries misalign_d=0.
- When undefined: the port does not exist and targets are used verbatim.

Decomposition:
- Shared package pipe_pkg: NOP_INSTR and RESET_PC constants, plus enum fetch_state_t {RUN, PEND}. The same package is used by the decode and hazard stages.
- PC+4 is computed with the team's existing parameterised adder block.
- One sub-module is natural: if_id_reg, the IF/ID register with reset/flush/stall enable, parameterised on WIDTH.

Test Plan:
- Reset, then imem_ready=1 for 4 cycles: pc_f steps 0x0→0x4→0x8→0xC. Decode receives instr/pc pairs in order with valid_d=1.
- pc_f=0x10, pc_src_e pulse with pc_target_e=0x80, imem_ready=1: next pc_f=0x80. Decode gets one bubble (instr_d=0x13, valid_d=0); the next Decode instruction has pc_d=0x80.
- imem_ready=0 for 3 cycles, with pc_src_e (target 0x200) in cycle 1 and again (target 0x300) in cycle 2: state=PEND and imem_addr holds. When ready rises, pc_f=0x300 and Decode sees a bubble.
- stall_f=stall_d=1 for 2 cycles: pc_f and all Decode outputs hold. Then flush_d=1 with stall_d=0 gives valid_d=0.
- pc_f=32'hFFFF_FFFC advancing: next pc_f=0, and Decode shows pc_plus4_d=0 for that instruction.
- With PC_ALIGN_CHECK_EN, redirect to 0x102: pc_f=0x100, and the first Decode instruction from it carries misalign_d=1, the next one 0.
